// File: rtl/piso_serializer_if.sv
// Load-side handshake bundle for the parallel-in, serial-out shifter.
// The producer drives the word; the serializer answers with load_ready.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] parallel_in;

    modport master (
        output load_valid,
        output parallel_in,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  parallel_in,
        output load_ready
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: one bit per shift strobe, done pulse
// after the last bit, shares strobe/mode gating with the deserializer.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode_select,
    input  logic                shift,
    input  logic                abort,
    piso_serializer_if.slave    ld,
    output logic                serial_out,
    output logic                serial_valid,
    output logic                busy,
    output logic                done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        // mode_select low freezes everything, including a pending done
        if (mode_select) begin
            if (abort) begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ld.load_valid) begin
                            state_d = SHIFT;
                            sreg_d  = ld.parallel_in;
                            cnt_d   = '0;
                        end
                    end
                    SHIFT: begin
                        if (shift) begin
                            if (cnt_q == LAST) begin
                                state_d = DONE;
                                sreg_d  = '0;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                                if (MSB_FIRST)
                                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                                else
                                    sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                            end
                        end
                    end
                    DONE: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                    default: begin
                        state_d = IDLE;
                        sreg_d  = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign tap           = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign serial_valid  = (state_q == SHIFT);
    assign serial_out    = serial_valid & tap;
    assign busy          = (state_q == SHIFT) || (state_q == DONE);
    assign done          = (state_q == DONE);
    assign ld.load_ready = (state_q == IDLE) && mode_select;

endmodule
